// File: rtl/bcd_display_pkg.sv
// Shared constants for the two-digit BCD display: segment patterns (active-low,
// gfedcba), converter states and the double-dabble iteration count.
package bcd_display_pkg;

  localparam int unsigned BCD_ITERS = 7;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    IDLE,
    CONV
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_2_bin_to_bcd.sv
// Sequential 7-bit binary to BCD converter (shift-add-3), restarting whenever
// the input differs from the last converted value; outputs only full results.
module bin_to_bcd_7
  import bcd_display_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] count_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid,
  output logic       ovf
);

  conv_state_e r_state, w_state_next;
  logic [6:0]  r_shift;
  logic [6:0]  r_last_val;
  logic [9:0]  r_acc;
  logic [9:0]  w_acc_adj;
  logic [9:0]  w_acc_next;
  logic [2:0]  r_iter;
  logic        r_pend;
  logic        w_start;
  logic        w_done;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic        r_valid;
  logic        r_ovf;

  // Hundreds field is at most 1 for a 7-bit input, so it never needs adjusting.
  always_comb begin
    w_acc_adj = r_acc;
    if (r_acc[3:0] >= 4'd5) w_acc_adj[3:0] = r_acc[3:0] + 4'd3;
    if (r_acc[7:4] >= 4'd5) w_acc_adj[7:4] = r_acc[7:4] + 4'd3;
    w_acc_next = {w_acc_adj[8:0], r_shift[6]};
  end

  assign w_start = (r_state == IDLE) && (r_pend || (count_in != r_last_val));
  assign w_done  = (r_state == CONV) && (r_iter == 3'(BCD_ITERS - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = CONV;
      CONV:    if (w_done)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_pend     <= 1'b1;
      r_last_val <= '0;
      r_shift    <= '0;
      r_acc      <= '0;
      r_iter     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_shift    <= count_in;
        r_last_val <= count_in;
        r_acc      <= '0;
        r_iter     <= '0;
        r_pend     <= 1'b0;
      end else if (r_state == CONV) begin
        r_acc   <= w_acc_next;
        r_shift <= {r_shift[5:0], 1'b0};
        r_iter  <= r_iter + 3'd1;
      end
      if (w_done) begin
        r_tens  <= w_acc_next[7:4];
        r_ones  <= w_acc_next[3:0];
        r_ovf   <= (w_acc_next[9:8] != 2'd0);
        r_valid <= 1'b1;
      end
    end
  end

  assign tens  = r_tens;
  assign ones  = r_ones;
  assign valid = r_valid;
  assign ovf   = r_ovf;

endmodule

// File: rtl/bcd_display_2.sv
// Two-digit common-anode display driver: BCD conversion plus digit multiplexing.
// Optional blinking while stopped is enabled by defining BCD_DISPLAY_BLINK_EN.
module bcd_display_2
  import bcd_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLINK_DIV   = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] count_in,
  input  logic       stop,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid,
  output logic       ovf,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] r_refresh;
  logic          r_sel;
  logic          w_wrap;
  logic          w_blank;
  logic [3:0]    w_digit;

  bin_to_bcd_7 u_conv (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .count_in (count_in),
    .tens     (tens),
    .ones     (ones),
    .valid    (valid),
    .ovf      (ovf)
  );

  assign w_wrap = (r_refresh == RW'(REFRESH_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_refresh <= '0;
      r_sel     <= 1'b0;
    end else if (w_wrap) begin
      r_refresh <= '0;
      r_sel     <= ~r_sel;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

`ifdef BCD_DISPLAY_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] r_blink;
  logic          r_phase;

  // Phase can only be set while stop is held, so it alone gates the anodes.
  always_ff @(posedge CLK) begin
    if (!RST_N || !stop) begin
      r_blink <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink == BW'(BLINK_DIV - 1)) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + 1'b1;
      end
    end
  end

  assign w_blank = r_phase;
`else
  logic w_unused_stop;
  assign w_unused_stop = stop & (BLINK_DIV != 0);
  assign w_blank       = 1'b0;
`endif

  assign w_digit = r_sel ? tens : ones;

  always_comb begin
    an  = 2'b11;
    seg = SEG_OFF;
    if (valid) begin
      an  = w_blank ? 2'b11 : (r_sel ? 2'b01 : 2'b10);
      seg = ovf ? SEG_DASH : seg_decode(w_digit);
    end
  end

endmodule
